// File: rtl/dma_pkg.sv
// Shared types and burst-sizing helper for the MM2S DMA reader.
package dma_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } dma_state_e;

  // Largest burst that fits the remaining count, the burst cap and the current 4 KB page.
  function automatic logic [31:0] burst_beats(input logic [11:0] addr,
                                              input logic [31:0] remaining,
                                              input logic [31:0] max_burst,
                                              input logic [31:0] bytes_per_beat);
    logic [31:0] to_page;
    logic [31:0] b;
    to_page = (32'd4096 - {20'd0, addr}) / bytes_per_beat;
    b = remaining;
    if (max_burst < b) b = max_burst;
    if (to_page < b)   b = to_page;
    return b;
  endfunction

endpackage

// File: rtl/dma_axis_skid.sv
// One-entry registered output stage for the AXI4-Stream master side.
module dma_axis_skid #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  input  logic              tready_i
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  assign in_ready_o = !valid_q || tready_i;
  assign tdata_o    = data_q;
  assign tvalid_o   = valid_q;
  assign tlast_o    = last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      last_q  <= in_last_i;
    end else if (tready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_mm2s_reader.sv
// Memory-to-stream DMA reader: splits a command into 4 KB-safe AXI4 INCR read
// bursts and forwards returned beats in order on an AXI4-Stream master.
module dma_mm2s_reader
  import dma_pkg::*;
#(
  parameter int ADDR_W          = 40,
  parameter int DATA_W          = 128,
  parameter int ID_W            = 4,
  parameter int LEN_W           = 24,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int BPB   = DATA_W / 8;
  localparam int OFF   = $clog2(BPB);
  localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, remaining_q, remaining_d, sent_q, sent_d;
  logic [OST_W-1:0]  ost_q, ost_d;
  logic              err_q, err_d, done_q;

  logic [LEN_W-1:0] beats;
  logic             ar_hs, r_active, skid_ready, r_hs, beat_last;

  assign beats = LEN_W'(burst_beats(addr_q[11:0], 32'(remaining_q), 32'(MAX_BURST), 32'(BPB)));

  // arvalid only drops through a handshake: outstanding can't rise without one.
  assign m_axi_arvalid = (state_q == ISSUE) && (ost_q < OST_W'(MAX_OUTSTANDING));
  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(beats - LEN_W'(1)) : '0;
  assign m_axi_arsize  = m_axi_arvalid ? 3'(OFF) : '0;
  assign m_axi_arburst = m_axi_arvalid ? BURST_INCR : '0;
  assign m_axi_arid    = '0;

  assign r_active     = (state_q == ISSUE) || (state_q == DRAIN);
  assign m_axi_rready = r_active && skid_ready;
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign beat_last    = (sent_q == len_q - LEN_W'(1));

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    err_d       = err_q;
    ost_d       = ost_q;
    if (r_hs) begin
      sent_d = sent_q + LEN_W'(1);
      if (axi_resp_e'(m_axi_rresp) inside {RESP_SLVERR, RESP_DECERR}) err_d = 1'b1;
    end
    case ({ar_hs, r_hs && m_axi_rlast})
      2'b10:   ost_d = ost_q + OST_W'(1);
      2'b01:   ost_d = ost_q - OST_W'(1);
      default: ost_d = ost_q;
    endcase
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d      = {cmd_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        len_d       = cmd_len;
        remaining_d = cmd_len;
        sent_d      = '0;
        err_d       = 1'b0;
        state_d     = (cmd_len == '0) ? DONE : ISSUE;
      end
      ISSUE: if (ar_hs) begin
        addr_d      = addr_q + (ADDR_W'(beats) << OFF);
        remaining_d = remaining_q - beats;
        if (remaining_q == beats) state_d = DRAIN;
      end
      DRAIN: if (sent_q == len_q && !m_axis_tvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      ost_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      ost_q       <= ost_d;
      err_q       <= err_d;
      done_q      <= (state_q == DONE);
    end
  end

  // Beats with nothing outstanding, or a foreign ID, are slave protocol violations.
  always @(posedge clk) begin
    if (!reset && r_hs) begin
      assert (ost_q != '0);
      assert (m_axi_rid == '0);
    end
  end

  dma_axis_skid #(.DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (m_axi_rvalid && r_active),
    .in_data_i  (m_axi_rdata),
    .in_last_i  (beat_last),
    .in_ready_o (skid_ready),
    .tdata_o    (m_axis_tdata),
    .tvalid_o   (m_axis_tvalid),
    .tlast_o    (m_axis_tlast),
    .tready_i   (m_axis_tready)
  );

endmodule
